mux8_rr_arbiter: RTL and testbench
==================================

Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8:1 data multiplexer among eight requesters.
- Registers a one-hot grant and drives the matching 3-bit select code, with a valid flag, into the mux's S2..S0 select inputs.
- Grants are held while the owner keeps its request high, up to a programmable tenure limit, then preempted.
- Sits between requester logic and the mux datapath; the mux itself is unchanged.

Parameters:
- NREQ, 8, number of requesters; fixed at 8 because select width is 3.
- SEL_W, 3, select code width (log2 NREQ).
- HOLD_MAX, 16, maximum consecutive cycles a single grant may be held; legal range 2..255.
- CNT_W, 8, width of the tenure counter; must hold HOLD_MAX-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  8  request vector; bit i means requester i wants the mux.
- grant  out  8  registered one-hot grant; all zeros when idle.
- sel  out  3  registered binary index of the granted requester; drives mux S2..S0.
- sel_valid  out  1  high whenever grant is non-zero.
- preempt  out  1  one-cycle pulse when a grant is removed by tenure timeout.
- lock  in  1  only present with MUX8_ARB_LOCK_EN.

Behaviour:
- Interface: one clock, clk; reset asynchronous, active-low, rst_n.
- Reset values: grant=0, sel=0, sel_valid=0, preempt=0, state=IDLE, hold counter=0, last-winner pointer=7, so requester 0 has first priority after reset.
- Two states:
  - IDLE: no grant.
  - OWN: grant held by index g.
- Round-robin pick: the search starts at (last+1) mod 8 and wraps. The winner becomes the new last.
- IDLE -> OWN: if req != 0 at edge T, the winner's grant, sel and sel_valid are visible after edge T. Latency is 1 cycle. If req == 0, stay in IDLE.
- OWN, normal hold: req[g]=1 and counter < HOLD_MAX-1. Hold grant and increment the counter.
- OWN, voluntary release: req[g]=0 at edge T.
  - Same edge, arbitrate among the remaining requests with g masked.
  - If any remain, the new owner is granted at T with no bubble and the counter resets to 0.
  - Else go to IDLE and grant=0.
- OWN, timeout: req[g]=1 and counter == HOLD_MAX-1.
  - Force release and pulse preempt for one cycle.
  - Arbitrate with g masked; if another request exists, grant it directly.
  - If g is the only requester, go to IDLE for exactly one cycle, then re-grant g through normal arbitration.
- A request that drops in the same cycle it would have won is not granted; arbitration uses req sampled at the edge.
- Invariants: grant is always zero or one-hot, and sel always equals the index of the set grant bit.
- When idle, sel holds its last value and sel_valid=0. Downstream logic must qualify the mux output with sel_valid.
- Reset asserted mid-grant: all outputs clear immediately and asynchronously. The pointer returns to 7.
- Counter saturates logic: it never exceeds HOLD_MAX-1 and resets on every new grant.

Optional Feature:
- Macro: MUX8_ARB_LOCK_EN.
- Defined: adds the lock input.
  - While lock=1 and in OWN, the tenure counter freezes and no timeout preemption occurs; voluntary release still works.
  - lock is ignored in IDLE.
  - lock deasserting resumes counting from the frozen value.
- Undefined: no lock port, and timeout is always enforced.

Decomposition:
- Package mux8_arb_pkg holds:
  - constants NREQ=8 and SEL_W=3;
  - the state typedef {IDLE, OWN};
  - a function converting one-hot to index.
- One sub-module, rr_pick8: combinational rotating-priority picker. Inputs are the request vector, the mask and the start pointer; outputs are the one-hot winner and a found flag. The top holds the FSM, counter, pointer and output registers.

Test Plan:
- Reset then req=8'b0000_0101 held: grant=0000_0001, sel=0 one cycle after the first edge. Drop req[0]: the next cycle grant=0000_0100, sel=2 with no idle cycle.
- req=8'hFF held with HOLD_MAX=4: owners rotate 0,1,2,...,7,0, each for exactly 4 cycles. preempt pulses at each handover and sel tracks the owner.
- Only req[5]=1 with HOLD_MAX=4: grant for 4 cycles, preempt pulse, one idle cycle with sel_valid=0, then re-grant to 5.
- After last winner=6, req=8'b1000_0011: grant goes to 7 first, then 0, then 1, confirming wrap-around.
- rst_n pulled low in the middle of an OWN tenure: grant, sel_valid and preempt go to 0 without waiting for a clock edge. After release, req=8'b1000_0000 is granted to requester 7 on the next edge.
- With MUX8_ARB_LOCK_EN, HOLD_MAX=4, req[3] held and lock=1 for 10 cycles: no preempt and the grant is held. lock=0 then causes preemption after the remaining count.

Source files
------------

// File: rtl/mux8_arb_pkg.sv
// ============================================================================
// Module      : mux8_arb_pkg
// Description : Shared constants, FSM state type and one-hot helper for the
//               8:1 mux round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux8_arb_pkg;

  localparam int NREQ  = 8;
  localparam int SEL_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Binary index of the set bit of a one-hot (or zero) vector.
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick8.sv
// ============================================================================
// Module      : rr_pick8
// Description : Combinational rotating-priority picker. Searches the unmasked
//               requests starting at start_i, wrapping modulo 8, and returns
//               the first hit as a one-hot winner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req_i,
  input  logic [NREQ-1:0]  mask_i,
  input  logic [SEL_W-1:0] start_i,
  output logic [NREQ-1:0]  win_o,
  output logic             found_o
);

  logic [NREQ-1:0] w_cand;

  assign w_cand = req_i & ~mask_i;

  // Walk the eight positions from start_i upward; the 3-bit add wraps for free.
  always_comb begin : p_pick
    logic [SEL_W-1:0] idx;
    logic             hit;
    win_o = '0;
    hit   = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = start_i + SEL_W'(i);
      if (!hit && w_cand[idx]) begin
        win_o[idx] = 1'b1;
        hit        = 1'b1;
      end
    end
    found_o = hit;
  end

endmodule

`default_nettype wire

// File: rtl/mux8_rr_arbiter.sv
// ============================================================================
// Module      : mux8_rr_arbiter
// Description : Round-robin arbiter driving the select inputs of a shared 8:1
//               mux. Grants are held while requested, up to HOLD_MAX cycles,
//               then preempted. Optional macro MUX8_ARB_LOCK_EN adds lock_i,
//               which freezes the tenure counter while an owner is granted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [SEL_W-1:0] sel_o,
  output logic             sel_valid_o,
  output logic             preempt_o
`ifdef MUX8_ARB_LOCK_EN
  ,
  input  logic             lock_i
`endif
);

  state_t           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             preempt_q, preempt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] last_q, last_d;

  logic             w_lock;
  logic             w_own_req;
  logic             w_timeout;
  logic             w_release;
  logic [NREQ-1:0]  w_mask;
  logic [SEL_W-1:0] w_start;
  logic [NREQ-1:0]  w_win;
  logic [SEL_W-1:0] w_win_idx;
  logic             w_found;

`ifdef MUX8_ARB_LOCK_EN
  assign w_lock = (state_q == OWN) && lock_i;
`else
  assign w_lock = 1'b0;
`endif

  // The current owner is masked so a released or timed-out owner never wins
  // back on the same edge; a lone requester re-wins from IDLE a cycle later.
  assign w_own_req = |(req_i & grant_q);
  assign w_timeout = (state_q == OWN) && w_own_req && !w_lock &&
                     (cnt_q == CNT_W'(HOLD_MAX - 1));
  assign w_release = (state_q == OWN) && (!w_own_req || w_timeout);
  assign w_mask    = (state_q == OWN) ? grant_q : '0;
  assign w_start   = last_q + SEL_W'(1);
  assign w_win_idx = onehot_to_idx(w_win);

  rr_pick8 u_pick (
    .req_i   (req_i),
    .mask_i  (w_mask),
    .start_i (w_start),
    .win_o   (w_win),
    .found_o (w_found)
  );

  // Next-state logic: grant on arrival, hold/count, release or preempt.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    preempt_d = 1'b0;
    cnt_d     = cnt_q;
    last_d    = last_q;
    case (state_q)
      IDLE: begin
        if (w_found) begin
          state_d = OWN;
          grant_d = w_win;
          sel_d   = w_win_idx;
          valid_d = 1'b1;
          cnt_d   = '0;
          last_d  = w_win_idx;
        end
      end
      OWN: begin
        if (!w_release) begin
          if (!w_lock) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          preempt_d = w_timeout;
          if (w_found) begin
            grant_d = w_win;
            sel_d   = w_win_idx;
            valid_d = 1'b1;
            cnt_d   = '0;
            last_d  = w_win_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; pointer resets to 7 so requester 0 goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
      cnt_q     <= '0;
      last_q    <= SEL_W'(NREQ - 1);
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      preempt_q <= preempt_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
    end
  end

  assign grant_o     = grant_q;
  assign sel_o       = sel_q;
  assign sel_valid_o = valid_q;
  assign preempt_o   = preempt_q;

endmodule

`default_nettype wire

// File: tb/tb_mux8_rr_arbiter.sv
// ============================================================================
// Module      : tb_mux8_rr_arbiter
// Description : Directed self-checking bench for mux8_rr_arbiter with
//               HOLD_MAX=4. Lock scenario is compiled in with MUX8_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux8_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       sel_valid;
  logic       preempt;
  logic       lock;

  int checks = 0;
  int errors = 0;

  mux8_rr_arbiter #(
    .HOLD_MAX (4),
    .CNT_W    (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .grant_o     (grant),
    .sel_o       (sel),
    .sel_valid_o (sel_valid),
    .preempt_o   (preempt)
`ifdef MUX8_ARB_LOCK_EN
    ,
    .lock_i      (lock)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] g, input logic [2:0] s,
                         input logic v, input logic p);
    chk({tag, ".grant"},   32'(grant),     32'(g));
    chk({tag, ".sel"},     32'(sel),       32'(s));
    chk({tag, ".valid"},   32'(sel_valid), 32'(v));
    chk({tag, ".preempt"}, 32'(preempt),   32'(p));
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    lock  = 1'b0;
    #3;
    chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    #5;
    rst_n = 1'b1;

    // Two requesters, then voluntary release hands over with no bubble.
    req = 8'b0000_0101;
    tick();
    chk_out("first_grant", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'b0000_0100;
    tick();
    chk_out("no_bubble", 8'h04, 3'd2, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    chk_out("idle_sel_hold", 8'h00, 3'd2, 1'b0, 1'b0);

    // Lone requester 5: four cycles, preempt into one idle cycle, re-grant.
    req = 8'b0010_0000;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_out($sformatf("solo_hold%0d", c), 8'h20, 3'd5, 1'b1, 1'b0);
    end
    tick();
    chk_out("solo_timeout", 8'h00, 3'd5, 1'b0, 1'b1);
    tick();
    chk_out("solo_regrant", 8'h20, 3'd5, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    chk_out("solo_release", 8'h00, 3'd5, 1'b0, 1'b0);

    // Reset so the pointer is back at 7, then full contention rotates 0..7,0.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        chk_out($sformatf("rot_o%0d_c%0d", k, c), 8'(1 << (k % 8)), 3'(k % 8), 1'b1,
                (c == 0) && (k > 0));
      end
    end
    req = 8'h00;
    tick();
    chk_out("rot_release", 8'h00, 3'd0, 1'b0, 1'b0);

    // Wrap-around: last winner 6, then 7 -> 0 -> 1.
    req = 8'b0100_0000;
    tick();
    chk_out("wrap_own6", 8'h40, 3'd6, 1'b1, 1'b0);
    req = 8'b1000_0011;
    tick();
    chk_out("wrap_to7", 8'h80, 3'd7, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) tick();
    tick();
    chk_out("wrap_to0", 8'h01, 3'd0, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) tick();
    tick();
    chk_out("wrap_to1", 8'h02, 3'd1, 1'b1, 1'b1);
    req = 8'h00;
    tick();
    chk_out("wrap_release", 8'h00, 3'd1, 1'b0, 1'b0);

    // Asynchronous reset while granted and preempt is high.
    req = 8'b0011_0000;
    for (int c = 0; c < 5; c++) tick();
    chk_out("pre_reset", 8'h20, 3'd5, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    req = 8'b1000_0000;
    tick();
    chk_out("post_reset7", 8'h80, 3'd7, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    chk_out("post_reset_idle", 8'h00, 3'd7, 1'b0, 1'b0);

`ifdef MUX8_ARB_LOCK_EN
    // Lock freezes tenure; unlocking resumes from the frozen count.
    req = 8'b0000_1000;
    tick();
    chk_out("lock_grant", 8'h08, 3'd3, 1'b1, 1'b0);
    lock = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_out($sformatf("lock_hold%0d", c), 8'h08, 3'd3, 1'b1, 1'b0);
    end
    lock = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_out($sformatf("unlock_hold%0d", c), 8'h08, 3'd3, 1'b1, 1'b0);
    end
    tick();
    chk_out("unlock_timeout", 8'h00, 3'd3, 1'b0, 1'b1);
    req = 8'h00;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
